// File: rtl/bsr_chain_if.sv
// Boundary scan register bus: TAP strobes, serial path and core/pad data.
interface bsr_chain_if #(
  parameter int W = 8
);
  logic [2:0]   instr_i;
  logic         shift_i;
  logic         capture_i;
  logic         update_i;
  logic         scan_i;
  logic         scan_o;
  logic [W-1:0] core_data_i;
  logic         core_oe_i;
  logic [W-1:0] pad_data_o;
  logic         pad_oe_o;
  logic [W-1:0] pad_data_i;
  logic [W-1:0] core_data_o;

  // TAP/core/pad side driving the register
  modport master (
    output instr_i, shift_i, capture_i, update_i, scan_i,
    output core_data_i, core_oe_i, pad_data_i,
    input  scan_o, pad_data_o, pad_oe_o, core_data_o
  );

  // Boundary scan register itself
  modport slave (
    input  instr_i, shift_i, capture_i, update_i, scan_i,
    input  core_data_i, core_oe_i, pad_data_i,
    output scan_o, pad_data_o, pad_oe_o, core_data_o
  );
endinterface

// File: rtl/bsr_chain.sv
// Boundary scan register for a W-pin bank: one input and one output cell per
// pin, a shared output-enable cell, a 1-bit bypass register and the
// instruction-driven pad/core muxing.
// Chain layout: bit 0 = OE control cell, bit 1+2i = input cell of pin i,
// bit 2+2i = output cell of pin i; bit L-1 is next to scan_o.
module bsr_chain #(
  parameter int           W    = 8,
  parameter logic [W-1:0] SAFE = {W{1'b0}}
) (
  input  logic        tck,
  input  logic        rst,
  bsr_chain_if.slave  bus
);

  localparam int L = 2 * W + 1;

  typedef enum logic [2:0] {
    INSTR_EXTEST = 3'b000,
    INSTR_SAMPLE = 3'b001,
    INSTR_INTEST = 3'b010,
    INSTR_CLAMP  = 3'b011,
    INSTR_HIGHZ  = 3'b100,
    INSTR_BYPASS = 3'b111
  } instr_e;

  // Update-register reset image: OE cell off, both pin cells at SAFE.
  function automatic logic [L-1:0] ur_reset_val();
    logic [L-1:0] v;
    v = {L{1'b0}};
    for (int i = 0; i < W; i++) begin
      v[1 + 2 * i] = SAFE[i];
      v[2 + 2 * i] = SAFE[i];
    end
    return v;
  endfunction

  logic [L-1:0] sr_q, sr_d;
  logic [L-1:0] ur_q, ur_d;
  logic         byp_q, byp_d;
  logic         bsr_sel_s;
  logic [W-1:0] ur_out_s;
  logic [W-1:0] ur_in_s;
  logic [W-1:0] pad_data_s;
  logic         pad_oe_s;
  logic [W-1:0] core_data_s;

  // EXTEST, SAMPLE/PRELOAD and INTEST route the data register through the BSR;
  // every other code (including the reserved ones) selects bypass.
  always_comb begin
    case (bus.instr_i)
      INSTR_EXTEST, INSTR_SAMPLE, INSTR_INTEST: bsr_sel_s = 1'b1;
      default:                                  bsr_sel_s = 1'b0;
    endcase
  end

  // Next-state for shift/capture/update; shift wins over capture and blocks update.
  always_comb begin
    sr_d  = sr_q;
    ur_d  = ur_q;
    byp_d = byp_q;
    if (bsr_sel_s) begin
      if (bus.shift_i) begin
        sr_d = {sr_q[L-2:0], bus.scan_i};
      end else if (bus.capture_i) begin
        sr_d[0] = bus.core_oe_i;
        for (int i = 0; i < W; i++) begin
          sr_d[1 + 2 * i] = bus.pad_data_i[i];
          sr_d[2 + 2 * i] = bus.core_data_i[i];
        end
      end else begin
        sr_d = sr_q;
      end
      if (bus.update_i && !bus.shift_i) begin
        ur_d = sr_q;
      end else begin
        ur_d = ur_q;
      end
    end else begin
      if (bus.shift_i) begin
        byp_d = bus.scan_i;
      end else if (bus.capture_i) begin
        byp_d = 1'b0;
      end else begin
        byp_d = byp_q;
      end
    end
  end

  // Chain, update and bypass state; reset discards any partial shift.
  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      sr_q  <= {L{1'b0}};
      ur_q  <= ur_reset_val();
      byp_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      ur_q  <= ur_d;
      byp_q <= byp_d;
    end
  end

  // Split the update register into per-pin output and input cell vectors.
  always_comb begin
    ur_out_s = {W{1'b0}};
    ur_in_s  = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      ur_out_s[i] = ur_q[2 + 2 * i];
      ur_in_s[i]  = ur_q[1 + 2 * i];
    end
  end

  // Pad/core muxing; functional pass-through unless the instruction takes over.
  always_comb begin
    pad_data_s  = bus.core_data_i;
    pad_oe_s    = bus.core_oe_i;
    core_data_s = bus.pad_data_i;
    case (bus.instr_i)
      INSTR_EXTEST: begin
        pad_data_s  = ur_out_s;
        pad_oe_s    = ur_q[0];
        core_data_s = ur_in_s;
      end
      INSTR_INTEST: begin
        pad_data_s  = SAFE;
        pad_oe_s    = 1'b0;
        core_data_s = ur_in_s;
      end
      INSTR_CLAMP: begin
        pad_data_s  = ur_out_s;
        pad_oe_s    = ur_q[0];
        core_data_s = bus.pad_data_i;
      end
      INSTR_HIGHZ: begin
        pad_data_s  = bus.core_data_i;
        pad_oe_s    = 1'b0;
        core_data_s = bus.pad_data_i;
      end
      default: begin
        pad_data_s  = bus.core_data_i;
        pad_oe_s    = bus.core_oe_i;
        core_data_s = bus.pad_data_i;
      end
    endcase
  end

  assign bus.scan_o      = bsr_sel_s ? sr_q[L-1] : byp_q;
  assign bus.pad_data_o  = pad_data_s;
  assign bus.pad_oe_o    = pad_oe_s;
  assign bus.core_data_o = core_data_s;

endmodule

// File: doc/bsr_chain.md
# bsr_chain

Parametrised boundary scan register for a W-pin I/O bank. It provides one output cell and one input cell per pin, a shared output-enable control cell, a 1-bit bypass register and instruction-driven pad/core muxing for EXTEST, SAMPLE/PRELOAD, INTEST, CLAMP, HIGHZ and BYPASS. It sits between the core and the pads and is driven by the TAP controller's DR strobes and decoded instruction.

## Interface
- W, 8, number of bidirectional pins
- SAFE, {W{1'b0}}, W-bit safe value loaded into update latches on reset and driven where a mode demands a safe state
- tck  in  1  JTAG test clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- instr_i  in  3  decoded instruction: 000 EXTEST, 001 SAMPLE/PRELOAD, 010 INTEST, 011 CLAMP, 100 HIGHZ, 111 BYPASS; 101/110 reserved, treated as BYPASS
- shift_i / capture_i / update_i  in  1 each  Shift-DR, Capture-DR, Update-DR strobes
- scan_i  in  1  serial TDI-side input
- scan_o  out  1  serial TDO-side output
- core_data_i  in  W  core → pad data
- core_oe_i  in  1  core output enable
- pad_data_o  out  W  data to pads
- pad_oe_o  out  1  enable to pads
- pad_data_i  in  W  pad → core data
- core_data_o  out  W  data to core

## Operation
- Chain length L = 2W+1. Shift register sr[L-1:0] and update register ur[L-1:0].
- Bit mapping: bit 0 is the control cell. Bit 1+2i is the input cell of pin i. Bit 2+2i is the output cell of pin i.
- BSR-selected instructions: EXTEST, SAMPLE, INTEST. Bypass-selected instructions: CLAMP, HIGHZ, BYPASS, reserved.
- When the BSR is selected:
  - shift_i: sr ← {sr[L-2:0], scan_i}.
  - Else capture_i: sr[0] ← core_oe_i, sr[1+2i] ← pad_data_i[i], sr[2+2i] ← core_data_i[i].
  - update_i && !shift_i: ur ← sr.
  - scan_o = sr[L-1].
- When bypass is selected:
  - shift_i: byp ← scan_i.
  - Else capture_i: byp ← 0.
  - scan_o = byp.
  - sr and ur hold; update_i is ignored.
- shift_i has priority over capture_i. update_i is ignored while shift_i is high.
- Output muxing (combinational):
  - SAMPLE, BYPASS, reserved (functional): pad_data_o = core_data_i, pad_oe_o = core_oe_i, core_data_o = pad_data_i.
  - EXTEST: pad_data_o[i] = ur[2+2i], pad_oe_o = ur[0], core_data_o[i] = ur[1+2i].
  - INTEST: pad_data_o = SAFE, pad_oe_o = 0, core_data_o[i] = ur[1+2i].
  - CLAMP: pad_data_o[i] = ur[2+2i], pad_oe_o = ur[0], core_data_o = pad_data_i.
  - HIGHZ: pad_data_o = core_data_i, pad_oe_o = 0, core_data_o = pad_data_i.
- Reset values: sr = 0, byp = 0, ur[0] = 0, ur[2+2i] = SAFE[i], ur[1+2i] = SAFE[i].
  - Resulting outputs: scan_o = 0. Mode-driven outputs take the reset ur values, e.g. under EXTEST pad_oe_o = 0 and pad_data_o = SAFE.

## Timing
- Reset acts immediately on assertion, regardless of tck. It is released synchronously into the next posedge by the integrator.
- Reset mid-shift discards the partial shift. ur is re-initialised, not retained.
- Capture, shift and update each take effect on the posedge where the strobe is sampled high. Pads and core see a new ur value from that same edge.
- scan_o changes only after posedge tck. Negedge retiming onto TDO belongs to the TAP, not this block.
- Muxing follows instr_i and ur combinationally, with zero-cycle latency on an instruction change.
- A full DR scan is 1 capture edge + L shift edges + 1 update edge.
- In BYPASS the serial latency is one tck per bit.

## Test plan
- Reset mid-shift (W=4, SAFE=4'b1010, instr=EXTEST): assert rst between shift edges → pad_oe_o=0, pad_data_o=4'b1010, core_data_o=4'b1010, scan_o=0 without a tck edge.
- SAMPLE capture (W=4): core_data_i=4'b0110, core_oe_i=1, pad_data_i=4'b1001; 1 capture edge, then 9 shift edges → scan_o sequence 0,1,1,0,1,0,0,1,1. Pads follow core throughout.
- PRELOAD then EXTEST: under SAMPLE, shift in a pattern loading ur outputs to 4'b1100 with oe=1, then update; pads stay functional. Switch instr_i to EXTEST → pad_data_o=4'b1100 and pad_oe_o=1 in the same cycle.
- BYPASS: capture, then shift scan_i = 1,0,1,1 → scan_o = 0 after capture, then 1,0,1,1 one edge late. sr and ur unchanged; update_i has no effect.
- CLAMP/HIGHZ: after EXTEST update, CLAMP keeps pad_data_o and pad_oe_o at the ur values with a 1-bit chain. HIGHZ forces pad_oe_o=0 with pad_data_o = core_data_i.
- Priority: shift_i and capture_i high together → shift occurs. update_i with shift_i high → ur unchanged.
